disp_sched: RTL

Round-robin scheduler that shares the board's 4-digit seven-segment display between two byte producers, the synchronous-link transmitter side (A) and receiver side (B). Each producer hands over a byte plus its parity bit through a valid/ready handshake. The block buffers one entry per producer and holds each shown value for a fixed dwell time. Its `numb`/`parity1` outputs drive the existing display driver's inputs directly.

---
 rtl/disp_pkg.sv | 14 +
 rtl/disp_sched_if.sv | 32 +++
 rtl/disp_slot.sv | 51 +++++
 rtl/disp_sched.sv | 110 +++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package disp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } disp_state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int unsigned DISP_DWELL_1S = 50_000_000;

endpackage

// File: rtl/disp_sched_if.sv
// Producer handshakes and display-driver outputs of the display scheduler.
interface disp_sched_if;

  // Handshake: a transfer happens at the posedge where x_valid && x_ready.
  // The producer holds x_data/x_parity stable while x_valid is high and
  // x_ready is low; x_ready depends only on registered state.
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_parity;
  logic       a_ready;

  logic       b_valid;
  logic [7:0] b_data;
  logic       b_parity;
  logic       b_ready;

  logic [7:0] numb;
  logic       parity1;
  logic       src;
  logic       busy;

  modport master (
    output a_valid, a_data, a_parity, b_valid, b_data, b_parity,
    input  a_ready, b_ready, numb, parity1, src, busy
  );

  modport slave (
    input  a_valid, a_data, a_parity, b_valid, b_data, b_parity,
    output a_ready, b_ready, numb, parity1, src, busy
  );

endinterface

// File: rtl/disp_slot.sv
// One-entry holding register for a producer byte and its parity bit.
module disp_slot (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  input  logic       parity_i,
  input  logic       clear_i,
  output logic       ready_o,
  output logic       pend_o,
  output logic [7:0] data_o,
  output logic       parity_o
);

  logic       pend_q, pend_d;
  logic [7:0] data_q, data_d;
  logic       parity_q, parity_d;

  // clear_i is only raised while pend_q is set, so a freed slot cannot
  // accept at the same edge it is emptied.
  always_comb begin
    pend_d   = pend_q;
    data_d   = data_q;
    parity_d = parity_q;
    if (clear_i) begin
      pend_d = 1'b0;
    end else if (valid_i && !pend_q) begin
      pend_d   = 1'b1;
      data_d   = data_i;
      parity_d = parity_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q   <= 1'b0;
      data_q   <= 8'h00;
      parity_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      data_q   <= data_d;
      parity_q <= parity_d;
    end
  end

  assign ready_o  = !pend_q;
  assign pend_o   = pend_q;
  assign data_o   = data_q;
  assign parity_o = parity_q;

endmodule

// File: rtl/disp_sched.sv
// Round-robin sharing of the 4-digit display between producers A and B,
// holding each shown byte for DWELL_CYCLES clocks.
module disp_sched
  import disp_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = DISP_DWELL_1S
) (
  input  logic         clk,
  input  logic         reset,
  disp_sched_if.slave  bus,
  output disp_state_e  state_o
);

  localparam int unsigned CW = $clog2(DWELL_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL_CYCLES - 1);

  logic       pend_a, pend_b, par_a, par_b, clr_a, clr_b;
  logic [7:0] data_a, data_b;

  disp_slot u_slot_a (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (bus.a_valid),
    .data_i   (bus.a_data),
    .parity_i (bus.a_parity),
    .clear_i  (clr_a),
    .ready_o  (bus.a_ready),
    .pend_o   (pend_a),
    .data_o   (data_a),
    .parity_o (par_a)
  );

  disp_slot u_slot_b (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (bus.b_valid),
    .data_i   (bus.b_data),
    .parity_i (bus.b_parity),
    .clear_i  (clr_b),
    .ready_o  (bus.b_ready),
    .pend_o   (pend_b),
    .data_o   (data_b),
    .parity_o (par_b)
  );

  disp_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    numb_q;
  logic          parity_q, src_q, busy_q;
  logic          fav_b_q;

  logic          load_en, pick_b;

  // A load happens from IDLE, or from SHOW once the dwell has expired.
  assign load_en = ((state_q == IDLE) || (cnt_q == '0)) && (pend_a || pend_b);
  assign pick_b  = pend_b && (!pend_a || fav_b_q);
  assign clr_a   = load_en && !pick_b;
  assign clr_b   = load_en && pick_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      numb_q   <= 8'h00;
      parity_q <= 1'b0;
      src_q    <= SRC_A;
      busy_q   <= 1'b0;
      fav_b_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_en) begin
            state_q  <= SHOW;
            cnt_q    <= CNT_LOAD;
            numb_q   <= pick_b ? data_b : data_a;
            parity_q <= pick_b ? par_b : par_a;
            src_q    <= pick_b ? SRC_B : SRC_A;
            busy_q   <= 1'b1;
            fav_b_q  <= !pick_b;
          end
        end
        SHOW: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (load_en) begin
            cnt_q    <= CNT_LOAD;
            numb_q   <= pick_b ? data_b : data_a;
            parity_q <= pick_b ? par_b : par_a;
            src_q    <= pick_b ? SRC_B : SRC_A;
            fav_b_q  <= !pick_b;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.numb    = numb_q;
  assign bus.parity1 = parity_q;
  assign bus.src     = src_q;
  assign bus.busy    = busy_q;
  assign state_o     = state_q;

endmodule
